// File: rtl/npc_div_pkg.sv
// Shared definitions for the NPC execute-stage divider: FSM state encoding,
// counter sizing and the {signed, rem} op-select encoding used by decode.
package npc_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // {in_signed, in_rem} encoding of the four RV32M divide ops
    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_REMU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    // Width of the step counter; it must hold WIDTH-1
    function automatic int div_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step. Computes a - b as
// a + ~b + 1 over WIDTH+1 bits; the carry out of that sum is set exactly
// when a >= b, which is the "keep the difference" decision.
module div_trial_sub
    import npc_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_rem_shift,
    input  logic [WIDTH:0] i_divisor,
    output logic [WIDTH:0] o_diff,
    output logic           o_nonneg
);

    localparam logic [WIDTH+1:0] ONE = (WIDTH+2)'(1);

    logic [WIDTH+1:0] w_sum;

    assign w_sum    = {1'b0, i_rem_shift} + {1'b0, ~i_divisor} + ONE;
    assign o_diff   = w_sum[WIDTH:0];
    assign o_nonneg = w_sum[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient
// bit per cycle behind a valid/ready handshake; divide-by-zero and signed
// overflow are resolved at accept and skip the iteration entirely.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a request
// CALC  | one shift/trial-subtract step per cycle, WIDTH cycles in total
// DONE  | first cycle registers the signed result, then holds it until
//       | out_ready
module seq_divider
    import npc_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int                   DIV_CNT_W = div_cnt_w(WIDTH);
    localparam logic [DIV_CNT_W-1:0] CNT_LOAD  = DIV_CNT_W'(WIDTH - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ONE   = DIV_CNT_W'(1);
    localparam logic [WIDTH-1:0]     ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]     MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negation; the most negative value wraps onto itself,
    // which is also its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    div_state_e           r_state;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvsr;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic                 r_sel_rem;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_result;
    logic                 r_busy;

    // Request decode
    logic [1:0]       w_op;
    logic             w_op_signed;
    logic             w_op_rem;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_accept;

    assign w_op        = {in_signed, in_rem};
    assign w_op_signed = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_op_rem    = (w_op == OP_REMU) || (w_op == OP_REM);
    assign w_dvd_neg   = w_op_signed & in_dividend[WIDTH-1];
    assign w_dvs_neg   = w_op_signed & in_divisor[WIDTH-1];
    assign w_dvd_mag   = w_dvd_neg ? neg(in_dividend) : in_dividend;
    assign w_dvs_mag   = w_dvs_neg ? neg(in_divisor) : in_divisor;
    assign w_div_zero  = (in_divisor == '0);
    assign w_ovf       = w_op_signed && (in_dividend == MOST_NEG) && (in_divisor == '1);
    assign w_accept    = in_valid && r_in_ready;

    // Iteration datapath: shift the next dividend bit into the partial
    // remainder and trial-subtract the divisor magnitude.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_nonneg;

    assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

    div_trial_sub #(
        .WIDTH(WIDTH)
    ) u_trial_sub (
        .i_rem_shift(w_shift),
        .i_divisor  ({1'b0, r_dvsr}),
        .o_diff     (w_diff),
        .o_nonneg   (w_nonneg)
    );

    // The kept remainder is always below the divisor, so its top bit is zero
    logic w_unused_rem_msb;
    assign w_unused_rem_msb = r_rem[WIDTH];

    // Sign correction and quotient/remainder select for the DONE register
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_result;

    assign w_rem_mag = r_rem[WIDTH-1:0];
    assign w_rem_fix = r_r_neg ? neg(w_rem_mag) : w_rem_mag;
    assign w_quo_fix = r_q_neg ? neg(r_quo) : r_quo;
    assign w_result  = r_sel_rem ? w_rem_fix : w_quo_fix;

    // Control FSM and datapath registers; flush acts exactly like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvsr       <= '0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_sel_rem    <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_sel_rem  <= w_op_rem;
                        r_dvsr     <= w_dvs_mag;
                        r_cnt      <= CNT_LOAD;
                        if (w_div_zero) begin
                            // quotient all ones, remainder is the raw dividend
                            r_quo   <= '1;
                            r_rem   <= {1'b0, in_dividend};
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_state <= DONE;
                        end else if (w_ovf) begin
                            // MOST_NEG / -1: quotient wraps to the dividend
                            r_quo   <= in_dividend;
                            r_rem   <= '0;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_quo   <= w_dvd_mag;
                            r_rem   <= '0;
                            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                            r_r_neg <= w_dvd_neg;
                            r_state <= CALC;
                        end
                    end
                end

                CALC: begin
                    r_rem <= w_nonneg ? w_diff : w_shift;
                    r_quo <= {r_quo[WIDTH-2:0], w_nonneg};
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                DONE: begin
                    if (!r_out_valid) begin
                        r_out_result <= w_result;
                        r_out_valid  <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign busy       = r_busy;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, randomized
// operands against a behavioural model, and hand-written backpressure,
// flush and reset sequences. Expected results go through a scoreboard queue.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic         in_rem;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_rem     (in_rem),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    typedef struct {
        string        name;
        bit           sgn;
        bit           rem;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, req);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Reference model following the RISC-V M rules
    function automatic logic [W-1:0] model(input bit s, input bit r,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        if (b == '0) return r ? a : '1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? '0 : a;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return r ? W'(sa % sb) : W'(sa / sb);
        end
        return r ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Present one request and hold it for exactly the accept edge
    task automatic send(input bit s, input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk_bit("send_ready_timeout", in_ready, 1'b1);
        in_signed   = s;
        in_rem      = r;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen
    task automatic wait_valid(input string name, input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int({name, "_latency"}, n, lat);
    endtask

    task automatic check_pop(input string name);
        logic [W-1:0] want;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got 0x%h want <queue empty>", name, out_result);
        end else begin
            want = exp_q.pop_front();
            chk(name, out_result, want);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input bit s, input bit r,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat);
        send(s, r, a, b, 1'b1, exp);
        wait_valid(name, lat);
        check_pop(name);
        handshake();
    endtask

    task automatic check_reset_values(input string name);
        chk_bit({name, "_in_ready"}, in_ready, 1'b1);
        chk_bit({name, "_out_valid"}, out_valid, 1'b0);
        chk_bit({name, "_busy"}, busy, 1'b0);
        chk({name, "_out_result"}, out_result, '0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;
        bit           rr;
        bit           saw;

        vecs[0]  = '{"divu_100_7",      1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",      1'b0, 1'b1, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m7_2",        1'b1, 1'b0, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{"rem_m7_2",        1'b1, 1'b1, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{"rem_7_m2",        1'b1, 1'b1, 32'h7,          32'hFFFF_FFFE,  32'h1,          33};
        vecs[5]  = '{"divu_by_zero",    1'b0, 1'b0, 32'h1234,       32'h0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{"remu_by_zero",    1'b0, 1'b1, 32'h1234,       32'h0,          32'h1234,       1};
        vecs[7]  = '{"rem_by_zero",     1'b1, 1'b1, 32'h1234,       32'h0,          32'h1234,       1};
        vecs[8]  = '{"div_neg_by_zero", 1'b1, 1'b0, 32'hFFFF_FFF9,  32'h0,          32'hFFFF_FFFF,  1};
        vecs[9]  = '{"div_overflow",    1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[10] = '{"rem_overflow",    1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
        vecs[11] = '{"divu_no_ovf",     1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          33};
        vecs[12] = '{"div_minneg_1",    1'b1, 1'b0, 32'h8000_0000,  32'h1,          32'h8000_0000,  33};
        vecs[13] = '{"divu_max_1",      1'b0, 1'b0, 32'hFFFF_FFFF,  32'h1,          32'hFFFF_FFFF,  33};
        vecs[14] = '{"divu_small",      1'b0, 1'b0, 32'd5,          32'd7,          32'd0,          33};
        vecs[15] = '{"div_m100_m7",     1'b1, 1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hE,          33};
        vecs[16] = '{"rem_m100_m7",     1'b1, 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};

        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_rem      = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = W'($urandom_range(1, 20));
                2:       rb = ~W'($urandom_range(0, 19));
                3:       rb = $urandom >> $urandom_range(1, 30);
                default: rb = '0;
            endcase
            if (i == 5) begin
                rs = 1'b1;
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run_op($sformatf("rand%0d", i), rs, rr, ra, rb, model(rs, rr, ra, rb),
                   model_lat(rs, ra, rb));
        end

        // Backpressure: result held, in_ready low, stray requests ignored
        send(1'b0, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14);
        wait_valid("bp", 33);
        check_pop("bp_result");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_signed   = 1'b0;
                in_rem      = 1'b0;
                in_dividend = 32'd50;
                in_divisor  = 32'd5;
                in_valid    = 1'b1;
            end
            @(posedge clk); #1;
            chk($sformatf("bp_hold_result%0d", i), out_result, 32'd14);
            chk_bit($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
            chk_bit($sformatf("bp_hold_in_ready%0d", i), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        handshake();
        chk_bit("bp_after_hs_in_ready", in_ready, 1'b1);
        chk_bit("bp_after_hs_out_valid", out_valid, 1'b0);
        send(1'b0, 1'b0, 32'd9, 32'd3, 1'b1, 32'd3);
        chk_bit("bp_next_accepted_busy", busy, 1'b1);
        wait_valid("bp_next", 33);
        check_pop("bp_next_result");
        handshake();

        // Flush at CALC cycle 10
        send(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0, '0);
        repeat (9) @(posedge clk);
        #1;
        chk_bit("flush_pre_busy", busy, 1'b1);
        chk_bit("flush_pre_in_ready", in_ready, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_reset_values("flush");
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        chk_bit("flush_no_out_valid", saw, 1'b0);
        run_op("post_flush_divu_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33);

        // Reset at CALC cycle 20
        send(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, '0);
        repeat (19) @(posedge clk);
        #1;
        chk_bit("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("rst_abort");
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        chk_bit("rst_no_out_valid", saw, 1'b0);
        run_op("post_rst_divu_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33);

        // Flush while a result is pending in DONE drops it
        send(1'b0, 1'b0, 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF);
        wait_valid("pend", 1);
        check_pop("pend_result");
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_reset_values("pend_flush");

        chk_int("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
